// File: rtl/mpe_pkg.sv
// Shared definitions for the mpe_pipe reproduction engine: header field positions,
// configuration register map, gene-type encoding and small helpers.
package mpe_pkg;

   // Header field positions, counted in ATTR_SZ-wide fields above attr[NUM_ATTR-1]
   localparam int TYPE       = 0;
   localparam int KEY_LO     = 1;
   localparam int KEY_HI     = 2;
   localparam int CHILD_ID   = 3;
   localparam int HDR_FIELDS = 4;

   localparam logic [4:0] CFG_P1_FIT    = 5'd0;
   localparam logic [4:0] CFG_P2_FIT    = 5'd1;
   localparam logic [4:0] CFG_CHILD_ID  = 5'd2;
   localparam logic [4:0] CFG_NODE_PROB = 5'd3;

   typedef enum logic {
      GT_NODE = 1'b0,
      GT_CONN = 1'b1
   } gene_type_e;

   function automatic int fld_lsb(input int num_attr, input int attr_sz, input int hdr_idx);
      return (num_attr + hdr_idx) * attr_sz;
   endfunction

   // Connection probabilities follow the node probability block
   function automatic logic [4:0] conn_prob_base(input int num_attr);
      return CFG_NODE_PROB + 5'(num_attr);
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + 4'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/mpe_attr_lane.sv
// One attribute lane: crossover parent select and probability-gated mutation.
// Latency: purely combinational (the two halves feed different pipeline stages).
// Backpressure: none; stalling is handled by the enclosing pipeline registers.
module mpe_attr_lane
   import mpe_pkg::*;
#(
   parameter int ATTR_SZ = 8
) (
   input  logic [ATTR_SZ-1:0] attr1,
   input  logic [ATTR_SZ-1:0] attr2,
   input  logic               key_eq,
   input  logic               bias,
   input  logic               rx_msb,
   output logic [ATTR_SZ-1:0] xattr,
   input  logic [ATTR_SZ-1:0] cur_attr,
   input  logic [ATTR_SZ-1:0] rand_m,
   input  logic [ATTR_SZ-1:0] prob,
   output logic               mut,
   output logic [ATTR_SZ-1:0] mattr
);

   logic sel;

   always_comb begin
      // Matching genes pick a random parent per lane; disjoint genes follow the fitter one
      sel   = key_eq ? rx_msb : bias;
      xattr = sel ? attr2 : attr1;
      // Strict compare: prob 0 never mutates, all-ones still spares rand all-ones
      mut   = (rand_m < prob);
      mattr = mut ? rand_m : cur_attr;
   end

endmodule

// File: rtl/mpe_pipe.sv
// NEAT reproduction pipeline: crossover then mutation, one child gene per beat; MPE_STATS_EN adds mut_cnt.
// Latency: 3 cycles from input handshake to child_gene; throughput 1 gene/cycle.
// Backpressure: out_ready low freezes every stage and drops in_ready in the same cycle.
module mpe_pipe
   import mpe_pkg::*;
#(
   parameter  int ATTR_SZ  = 8,
   parameter  int NUM_ATTR = 4,
   localparam int GENE_SZ  = (NUM_ATTR + HDR_FIELDS) * ATTR_SZ
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_we,
   input  logic [4:0]                  cfg_addr,
   input  logic [ATTR_SZ-1:0]          cfg_data,
   output logic                        cfg_busy,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [GENE_SZ-1:0]          gene1,
   input  logic [GENE_SZ-1:0]          gene2,
   input  logic [NUM_ATTR*ATTR_SZ-1:0] rand_x,
   input  logic [NUM_ATTR*ATTR_SZ-1:0] rand_m,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [GENE_SZ-1:0]          child_gene,
   output logic [15:0]                 mut_cnt
);

   localparam int         AW        = NUM_ATTR * ATTR_SZ;
   localparam int         KEY_LSB   = fld_lsb(NUM_ATTR, ATTR_SZ, KEY_LO);
   localparam int         KEY_W     = 2 * ATTR_SZ;
   localparam int         CID_LSB   = fld_lsb(NUM_ATTR, ATTR_SZ, CHILD_ID);
   localparam int         CARRY_W   = CID_LSB - AW;
   localparam logic [4:0] CONN_BASE = conn_prob_base(NUM_ATTR);

   // ---------------- configuration registers ----------------
   logic [ATTR_SZ-1:0]               p1_fit;
   logic [ATTR_SZ-1:0]               p2_fit;
   logic [ATTR_SZ-1:0]               child_id;
   logic [NUM_ATTR-1:0][ATTR_SZ-1:0] node_prob;
   logic [NUM_ATTR-1:0][ATTR_SZ-1:0] conn_prob;
   logic                             cfg_wr;

   assign cfg_wr = cfg_we && !cfg_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1_fit    <= '0;
         p2_fit    <= '0;
         child_id  <= '0;
         node_prob <= '0;
         conn_prob <= '0;
      end else if (cfg_wr) begin
         if (cfg_addr == CFG_P1_FIT)   p1_fit   <= cfg_data;
         if (cfg_addr == CFG_P2_FIT)   p2_fit   <= cfg_data;
         if (cfg_addr == CFG_CHILD_ID) child_id <= cfg_data;
         for (int i = 0; i < NUM_ATTR; i++) begin
            if (cfg_addr == CFG_NODE_PROB + 5'(i)) node_prob[i] <= cfg_data;
            if (cfg_addr == CONN_BASE + 5'(i))     conn_prob[i] <= cfg_data;
         end
      end
   end

   // ---------------- pipeline control ----------------
   logic en;
   logic s1_vld;
   logic s2_vld;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign cfg_busy = s1_vld || s2_vld || out_valid;

   // ---------------- S1: capture ----------------
   logic [CID_LSB-1:0]  s1_g1;
   logic [CID_LSB-1:0]  s1_g2;
   logic [NUM_ATTR-1:0] s1_xsel;
   logic [AW-1:0]       s1_rm;
   logic [NUM_ATTR-1:0] x_msb;

   always_comb begin
      x_msb = '0;
      for (int i = 0; i < NUM_ATTR; i++) begin
         x_msb[i] = rand_x[i*ATTR_SZ + ATTR_SZ - 1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld  <= 1'b0;
         s1_g1   <= '0;
         s1_g2   <= '0;
         s1_xsel <= '0;
         s1_rm   <= '0;
      end else if (en) begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_g1   <= gene1[CID_LSB-1:0];
            s1_g2   <= gene2[CID_LSB-1:0];
            s1_xsel <= x_msb;
            s1_rm   <= rand_m;
         end
      end
   end

   // ---------------- S2: crossover ----------------
   logic               bias;
   logic               key_eq;
   logic [CARRY_W-1:0] fit_hdr;
   logic [AW-1:0]      x_attr;
   logic [CARRY_W-1:0] s2_hdr;
   logic [AW-1:0]      s2_xattr;
   logic [AW-1:0]      s2_rm;

   // Equal fitness favours parent1
   assign bias    = (p2_fit > p1_fit);
   assign key_eq  = (s1_g1[KEY_LSB +: KEY_W] == s1_g2[KEY_LSB +: KEY_W]);
   assign fit_hdr = bias ? s1_g2[AW +: CARRY_W] : s1_g1[AW +: CARRY_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_vld   <= 1'b0;
         s2_hdr   <= '0;
         s2_xattr <= '0;
         s2_rm    <= '0;
      end else if (en) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_hdr   <= fit_hdr;
            s2_xattr <= x_attr;
            s2_rm    <= s1_rm;
         end
      end
   end

   // ---------------- S3: mutation into output register ----------------
   gene_type_e                       s2_gtype;
   logic [NUM_ATTR-1:0][ATTR_SZ-1:0] prob_sel;
   logic [NUM_ATTR-1:0]              lane_mut;
   logic [AW-1:0]                    m_attr;

   assign s2_gtype = gene_type_e'(s2_hdr[TYPE*ATTR_SZ]);

   always_comb begin
      prob_sel = '0;
      for (int i = 0; i < NUM_ATTR; i++) begin
         prob_sel[i] = (s2_gtype == GT_CONN) ? conn_prob[i] : node_prob[i];
      end
   end

   for (genvar i = 0; i < NUM_ATTR; i++) begin : g_lane
      mpe_attr_lane #(
         .ATTR_SZ (ATTR_SZ)
      ) u_lane (
         .attr1    (s1_g1[i*ATTR_SZ +: ATTR_SZ]),
         .attr2    (s1_g2[i*ATTR_SZ +: ATTR_SZ]),
         .key_eq   (key_eq),
         .bias     (bias),
         .rx_msb   (s1_xsel[i]),
         .xattr    (x_attr[i*ATTR_SZ +: ATTR_SZ]),
         .cur_attr (s2_xattr[i*ATTR_SZ +: ATTR_SZ]),
         .rand_m   (s2_rm[i*ATTR_SZ +: ATTR_SZ]),
         .prob     (prob_sel[i]),
         .mut      (lane_mut[i]),
         .mattr    (m_attr[i*ATTR_SZ +: ATTR_SZ])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         child_gene <= '0;
      end else if (en) begin
         out_valid <= s2_vld;
         if (s2_vld) begin
            child_gene <= {child_id, s2_hdr, m_attr};
         end
      end
   end

   // Parent child-id fields and low random bits carry no information for the child
   logic unused_in;
   assign unused_in = ^{gene1[CID_LSB +: ATTR_SZ], gene2[CID_LSB +: ATTR_SZ], rand_x};

`ifdef MPE_STATS_EN
   logic [NUM_ATTR-1:0] out_mut;
   logic [16:0]         cnt_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_mut <= '0;
      end else if (en && s2_vld) begin
         out_mut <= lane_mut;
      end
   end

   assign cnt_sum = {1'b0, mut_cnt} + 17'(popcount8(8'(out_mut)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mut_cnt <= '0;
      end else if (out_valid && out_ready) begin
         mut_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
   end
`else
   logic unused_mut;
   assign unused_mut = ^lane_mut;
   assign mut_cnt    = '0;
`endif

endmodule

// File: tb/tb_mpe_pipe.sv
// Directed bench for mpe_pipe (ATTR_SZ=8, NUM_ATTR=4): crossover, mutation, stalls,
// busy config writes, mid-stream reset and, with MPE_STATS_EN, the mutation counter.
module tb_mpe_pipe;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        cfg_busy;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] gene1;
   logic [63:0] gene2;
   logic [31:0] rand_x;
   logic [31:0] rand_m;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] child_gene;
   logic [15:0] mut_cnt;

   int checks   = 0;
   int failures = 0;

   mpe_pipe #(
      .ATTR_SZ  (8),
      .NUM_ATTR (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_busy   (cfg_busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .gene1      (gene1),
      .gene2      (gene2),
      .rand_x     (rand_x),
      .rand_m     (rand_m),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .child_gene (child_gene),
      .mut_cnt    (mut_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic [4:0] a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
   endtask

   function automatic logic [63:0] mk(input logic [7:0] cid, input logic [7:0] khi,
                                      input logic [7:0] klo, input logic [7:0] typ,
                                      input logic [31:0] at);
      return {cid, khi, klo, typ, at};
   endfunction

   // Single beat through an idle pipeline with out_ready high: must appear after exactly 3 edges
   task automatic run_beat(input string tag, input logic [63:0] g1, input logic [63:0] g2,
                           input logic [31:0] rx, input logic [31:0] rm, input logic [63:0] exp);
      gene1    = g1;
      gene2    = g2;
      rand_x   = rx;
      rand_m   = rm;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk({tag, "_early"}, 64'(out_valid), 64'd0);
      tick();
      chk({tag, "_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_dat"}, child_gene, exp);
      tick();
      chk({tag, "_drain"}, 64'(out_valid), 64'd0);
   endtask

   localparam logic [63:0] G1A = 64'hA1_01_02_00_11111111;
   localparam logic [63:0] G2A = 64'hA2_03_04_00_22222222;
   localparam logic [63:0] G2C = 64'hA2_03_04_01_22222222;
   localparam int          NB  = 6;

   initial begin
      logic [63:0] q[$];
      logic [63:0] prev;
      logic [63:0] exp;
      logic [3:0]  pat;
      logic [7:0]  b;
      logic        prev_stall;
      int          sent;
      int          rcvd;

      rst       = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      in_valid  = 1'b0;
      gene1     = '0;
      gene2     = '0;
      rand_x    = '0;
      rand_m    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_child", child_gene, 64'd0);
      chk("rst_busy", 64'(cfg_busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mut_cnt", 64'(mut_cnt), 64'd0);
      rst = 1'b1;
      tick();

      cfg_wr(5'd0, 8'h10);
      cfg_wr(5'd1, 8'h20);
      cfg_wr(5'd2, 8'h55);

      // Disjoint keys, parent2 fitter
      run_beat("xover_disjoint", G1A, G2A, 32'h0, 32'h0, 64'h55_03_04_00_22222222);
      // Matching keys: lanes 0..3 select from rand_x MSB (80,00,FF,7F)
      run_beat("xover_match", 64'hA1_05_06_01_11121314, 64'hA2_05_06_00_21222324,
               32'h7F_FF_00_80, 32'h0, 64'h55_05_06_00_11221324);

      // Node mutation on lane 0 with prob 40
      cfg_wr(5'd3, 8'h40);
      run_beat("mut_node_3f", G1A, G2A, 32'h0, 32'h0000003F, 64'h55_03_04_00_2222223F);
      run_beat("mut_node_40", G1A, G2A, 32'h0, 32'h00000040, 64'h55_03_04_00_22222222);
      // Conn gene uses conn prob (lane0 conn prob 0, lane1 conn prob FF)
      cfg_wr(5'd8, 8'hFF);
      run_beat("mut_conn_fe", G1A, G2C, 32'h0, 32'h0000FE3F, 64'h55_03_04_01_2222FE22);
      run_beat("mut_conn_ff", G1A, G2C, 32'h0, 32'h0000FF00, 64'h55_03_04_01_22222222);

      // Equal fitness selects parent1
      cfg_wr(5'd1, 8'h10);
      run_beat("fit_equal", G1A, G2A, 32'h0, 32'hFFFFFFFF, 64'h55_01_02_00_11111111);
      cfg_wr(5'd1, 8'h20);

      // Continuous stream with out_ready pattern 1,0,0,1
      pat        = 4'b1001;
      sent       = 0;
      rcvd       = 0;
      prev       = '0;
      prev_stall = 1'b0;
      for (int c = 0; c < 200 && rcvd < NB; c++) begin
         out_ready = pat[c % 4];
         in_valid  = (sent < NB);
         b         = 8'(8'h60 + sent);
         gene1     = mk(8'hA1, 8'h10, 8'h50, 8'h00, 32'h11111111);
         gene2     = mk(8'hA2, 8'(8'h40 + sent), 8'h50, 8'h00, {4{b}});
         rand_x    = '0;
         rand_m    = 32'hFFFFFFFF;
         #1;
         if (prev_stall) chk("stall_hold", child_gene, prev);
         if (out_valid) chk("in_ready_follow", 64'(in_ready), 64'(out_ready));
         if (out_valid && out_ready) begin
            if (q.size() > 0) exp = q.pop_front();
            else exp = 'x;
            chk("stream_dat", child_gene, exp);
            rcvd++;
         end
         prev_stall = out_valid && !out_ready;
         prev       = child_gene;
         if (in_valid && in_ready) begin
            q.push_back(mk(8'h55, 8'(8'h40 + sent), 8'h50, 8'h00, {4{b}}));
            sent++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", 64'(rcvd), 64'(NB));
      tick();
      tick();
      tick();

      // Config write while busy is dropped
      gene1    = G1A;
      gene2    = G2A;
      rand_m   = 32'hFFFFFFFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("busy_flag", 64'(cfg_busy), 64'd1);
      cfg_wr(5'd2, 8'h99);
      tick();
      chk("busy_wr_vld", 64'(out_valid), 64'd1);
      chk("busy_wr_dropped", child_gene, 64'h55_03_04_00_22222222);
      tick();

      // Reset mid-stream
      in_valid = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_child", child_gene, 64'd0);
      chk("midrst_busy", 64'(cfg_busy), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      tick();
      chk("midrst_flushed", 64'(out_valid), 64'd0);
      // Config cleared: equal fitness, child id 0, no mutation
      run_beat("post_rst", G1A, G2A, 32'h0, 32'h0, 64'h00_01_02_00_11111111);

`ifdef MPE_STATS_EN
      chk("stats_zero", 64'(mut_cnt), 64'd0);
      cfg_wr(5'd3, 8'h80);
      cfg_wr(5'd4, 8'h80);
      for (int k = 0; k < 3; k++) begin
         run_beat("stats_beat", G1A, G2A, 32'h0, 32'hFFFF1010, 64'h00_01_02_00_11111010);
      end
      chk("stats_six", 64'(mut_cnt), 64'd6);
      cfg_wr(5'd5, 8'h80);
      cfg_wr(5'd6, 8'h80);
      rand_m   = 32'h0;
      in_valid = 1'b1;
      for (int k = 0; k < 16400; k++) begin
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("stats_sat", 64'(mut_cnt), 64'hFFFF);
`else
      chk("stats_off", 64'(mut_cnt), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mpe_pipe.md
# mpe_pipe

Parametrised, fully pipelined NEAT reproduction engine: takes one gene from each parent per beat, performs key-aware crossover and probability-gated mutation on NUM_ATTR attribute fields, and emits one child gene per beat. It sits between the parent-gene fetch stream and the child-genome writeback, with valid/ready handshakes on both sides. A register-mapped configuration port replaces the old setup-phase data reuse.

## Interface
- ATTR_SZ, 8, width of every gene field, fitness and probability value
- NUM_ATTR, 4, number of mutable attribute fields (1..8)
- GENE_SZ, derived (NUM_ATTR+4)*ATTR_SZ: fields from MSB are child id, key hi, key lo, type (bit 0 = gene_type: 0 node, 1 conn), then attr[NUM_ATTR-1..0]
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  5  0 p1_fit, 1 p2_fit, 2 child_id, 3..3+NUM_ATTR-1 node prob[i], 3+NUM_ATTR.. conn prob[i]
- cfg_data  in  ATTR_SZ  write data
- cfg_busy  out  1  any pipeline stage valid
- in_valid / in_ready  in / out  1  parent-pair handshake
- gene1, gene2  in  GENE_SZ  parent genes
- rand_x, rand_m  in  NUM_ATTR*ATTR_SZ  crossover / mutation random lanes
- out_valid / out_ready  out / in  1  child handshake
- child_gene  out  GENE_SZ  result
- mut_cnt  out  16  mutated-field count (MPE_STATS_EN only)

## Operation
- Config: write accepted only when cfg_busy=0; writes while busy are dropped, registers unchanged. Unmapped addresses ignored. All config resets to 0.
- bias = (p2_fit > p1_fit); equal fitness selects parent1.
- Stage 1 (S1): capture gene1, gene2, rand_x, rand_m on in_valid&&in_ready.
- Stage 2 (S2, crossover): per lane i, if key fields equal, sel[i] = rand_x[i] MSB, else sel[i] = bias; xattr[i] = sel ? gene2.attr[i] : gene1.attr[i]. Key/type fields taken from fitter parent. gene_type = fitter parent's type bit 0.
- Stage 3 (S3, mutation): prob[i] = gene_type ? conn prob[i] : node prob[i]; mutate iff rand_m[i] < prob[i] (unsigned, strict; prob 0 never mutates, 8'hFF mutates all but rand 8'hFF). Mutated value = rand_m[i]. Child id field = child_id register.
- Output register holds child_gene until out_ready.

## Timing
- Advance enable en = !out_valid || out_ready; all stages move together; in_ready = en.
- Latency: accepted beat appears on child_gene exactly 3 cycles later with no backpressure; throughput 1 gene/cycle.
- out_ready low: pipeline freezes, child_gene and all stage data stable, in_ready low same cycle (combinational from out_ready).
- Bubbles propagate as invalid stages; out_valid low for bubbles.
- Reset (asserted any time, including mid-stream): all valid bits 0, child_gene 0, out_valid 0, cfg_busy 0, mut_cnt 0, config 0; in-flight genes discarded. in_ready = 1 after reset.
- Config written in cycle N affects beats accepted in cycle N+1 onward.

## Configuration
- MPE_STATS_EN defined: mut_cnt increments by popcount of mutated lanes on each output handshake (out_valid&&out_ready), saturates at 16'hFFFF.
- Undefined: mut_cnt port driven 0, no counter logic.

## Structure
- Package mpe_pkg: field-index localparams (CHILD_ID, KEY_HI, KEY_LO, TYPE), cfg address constants, gene_type encoding.
- One sub-module mpe_attr_lane: combinational per-lane crossover select + mutation compare, instantiated NUM_ATTR times via generate.

## Test plan
- Config p1=10, p2=20, keys differ, gene1.attr=11.., gene2.attr=22.. -> child attrs all 22, key from gene2, latency 3 cycles.
- Keys equal, rand_x lanes 80,00,FF,7F -> attrs from gene2,gene1,gene2,gene1.
- Node gene, node prob[0]=40, rand_m[0]=3F then 40 -> attr0=3F (mutated), then crossover value unchanged; conn gene uses conn prob.
- Continuous input with out_ready toggling 1,0,0,1 -> no loss/duplication, child_gene stable while stalled, in_ready follows out_ready.
- cfg write with cfg_busy=1 -> ignored; rst low mid-stream -> out_valid 0, child_gene 0, config 0.
- MPE_STATS_EN: 3 beats with 2 mutated lanes each -> mut_cnt=6; preload near saturation -> holds FFFF.
